// File: rtl/fetch_sequencer_if.sv
// Memory-controller handshake between the fetch sequencer and the instruction/data ports.
// The sequencer is the master: it raises requests and receives read data and hit strobes.
interface fetch_sequencer_if;
    logic [31:0] imemload;
    logic        ihit;
    logic        dhit;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        dREN;
    logic        dWEN;

    modport master (
        input  imemload, ihit, dhit,
        output iREN, imemaddr, dREN, dWEN
    );

    modport slave (
        output imemload, ihit, dhit,
        input  iREN, imemaddr, dREN, dWEN
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multicycle instruction sequencer: owns the PC and steps each instruction through
// fetch, execute (with optional data access), then PC update or halt.
module fetch_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic                   CLK,
    input  logic                   nRST,
    fetch_sequencer_if.master      mem,
    input  logic [1:0]             PC_src,
    input  logic                   PC_EN,
    input  logic                   bra,
    input  logic                   MemRead,
    input  logic                   MemWrite,
    input  logic                   mem_halt,
    input  logic [31:0]            rs_data,
    output logic [5:0]             opcode,
    output logic [5:0]             funct,
    output logic [31:0]            instr,
    output logic [31:0]            pc_plus4,
    output logic                   exec_valid,
    output logic                   halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        halted_q, halted_d;
    logic [31:0] branch_off;
    logic [31:0] next_pc;
    logic        done;

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        next_pc    = pc_plus4;
        case (PC_src)
            2'b01:   if (bra) next_pc = pc_plus4 + branch_off;
            2'b10:   next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            2'b11:   next_pc = rs_data & 32'hFFFF_FFFC;
            default: next_pc = pc_plus4;
        endcase
    end

    // A data access finishes on dhit; instructions without one finish immediately.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        halted_d   = halted_q;
        mem.iREN   = 1'b0;
        mem.dREN   = 1'b0;
        mem.dWEN   = 1'b0;
        exec_valid = 1'b0;
        done       = ~(MemRead | MemWrite) | mem.dhit;

        case (state_q)
            FETCH: begin
                mem.iREN = 1'b1;
                if (mem.ihit) begin
                    instr_d = mem.imemload;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec_valid = 1'b1;
                mem.dREN   = MemRead;
                mem.dWEN   = MemWrite & ~MemRead;
                if (done) begin
                    if (mem_halt) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else if (PC_EN) begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= FETCH;
            pc_q     <= PC_INIT;
            instr_q  <= 32'h0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
        end
    end

    assign mem.imemaddr = pc_q;
    assign opcode       = instr_q[31:26];
    assign funct        = instr_q[5:0];
    assign instr        = instr_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer plus hand-written reset/halt/wrap sequences.
module tb_fetch_sequencer;

    typedef struct packed {
        logic        ihit;
        logic [31:0] imem;
        logic        dhit;
        logic [1:0]  src;
        logic        pcen;
        logic        bra;
        logic        mr;
        logic        mw;
        logic        hlt;
        logic [31:0] rs;
    } stim_t;

    typedef struct packed {
        logic        iren;
        logic [31:0] addr;
        logic        dren;
        logic        dwen;
        logic        ev;
        logic        hlt;
        logic [31:0] instr;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam int   NVEC = 27;

    logic        CLK;
    logic        nRST;
    logic [1:0]  PC_src;
    logic        PC_EN, bra, MemRead, MemWrite, mem_halt;
    logic [31:0] rs_data;
    logic [5:0]  opcode, funct;
    logic [31:0] instr, pc_plus4;
    logic        exec_valid, halted;

    int vectors;
    int miscompares;

    vec_t tbl [NVEC];

    fetch_sequencer_if bus ();

    fetch_sequencer #(.PC_INIT(32'h0000_0000)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .mem        (bus),
        .PC_src     (PC_src),
        .PC_EN      (PC_EN),
        .bra        (bra),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .mem_halt   (mem_halt),
        .rs_data    (rs_data),
        .opcode     (opcode),
        .funct      (funct),
        .instr      (instr),
        .pc_plus4   (pc_plus4),
        .exec_valid (exec_valid),
        .halted     (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic stim_t S(input logic ihit, input logic [31:0] imem, input logic dhit,
                                input logic [1:0] src, input logic pcen, input logic br,
                                input logic mr, input logic mw, input logic hl, input logic [31:0] rs);
        S = '{ihit, imem, dhit, src, pcen, br, mr, mw, hl, rs};
    endfunction

    function automatic exp_t E(input logic iren, input logic [31:0] addr, input logic dren,
                               input logic dwen, input logic ev, input logic hl, input logic [31:0] ins);
        E = '{iren, addr, dren, dwen, ev, hl, ins};
    endfunction

    task automatic applyStimulus(input stim_t s);
        bus.ihit     = s.ihit;
        bus.imemload = s.imem;
        bus.dhit     = s.dhit;
        PC_src       = s.src;
        PC_EN        = s.pcen;
        bra          = s.bra;
        MemRead      = s.mr;
        MemWrite     = s.mw;
        mem_halt     = s.hlt;
        rs_data      = s.rs;
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        logic [31:0] exp_p4;
        #1;
        exp_p4 = e.addr + 32'd4;
        vectors++;
        if (bus.iREN !== e.iren || bus.imemaddr !== e.addr || bus.dREN !== e.dren ||
            bus.dWEN !== e.dwen || exec_valid !== e.ev || halted !== e.hlt ||
            instr !== e.instr || opcode !== e.instr[31:26] || funct !== e.instr[5:0] ||
            pc_plus4 !== exp_p4) begin
            miscompares++;
            $display("[TB] FAIL %s: got iREN=%b addr=%h dREN=%b dWEN=%b ev=%b halted=%b instr=%h op=%h fn=%h p4=%h; want iREN=%b addr=%h dREN=%b dWEN=%b ev=%b halted=%b instr=%h p4=%h",
                     tag, bus.iREN, bus.imemaddr, bus.dREN, bus.dWEN, exec_valid, halted,
                     instr, opcode, funct, pc_plus4,
                     e.iren, e.addr, e.dren, e.dwen, e.ev, e.hlt, e.instr, exp_p4);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        applyStimulus(S(L, 32'h0, L, 2'd0, L, L, L, L, L, 32'h0));
    endtask

    task automatic doReset;
        nRST = 1'b0;
        idle();
        tick();
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nRST        = 1'b0;
        idle();

        // cycle-by-cycle program: addi, jr, beq taken/not, j, lw, sw, stall, halt
        tbl[0]  = '{S(L, 32'h0,         L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h000, L, L, L, L, 32'h0)};
        tbl[1]  = '{S(H, 32'h2001_0005, L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h000, L, L, L, L, 32'h0)};
        tbl[2]  = '{S(L, 32'h0,         L, 2'd0, H, L, L, L, L, 32'h0),  E(L, 32'h000, L, L, H, L, 32'h2001_0005)};
        tbl[3]  = '{S(H, 32'h03E0_0008, L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h004, L, L, L, L, 32'h2001_0005)};
        tbl[4]  = '{S(L, 32'h0,         L, 2'd3, H, L, L, L, L, 32'h13), E(L, 32'h004, L, L, H, L, 32'h03E0_0008)};
        tbl[5]  = '{S(H, 32'h1000_FFFD, L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h010, L, L, L, L, 32'h03E0_0008)};
        tbl[6]  = '{S(L, 32'h0,         L, 2'd1, H, H, L, L, L, 32'h0),  E(L, 32'h010, L, L, H, L, 32'h1000_FFFD)};
        tbl[7]  = '{S(H, 32'h1000_FFFD, L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h008, L, L, L, L, 32'h1000_FFFD)};
        tbl[8]  = '{S(L, 32'h0,         L, 2'd1, H, L, L, L, L, 32'h0),  E(L, 32'h008, L, L, H, L, 32'h1000_FFFD)};
        tbl[9]  = '{S(H, 32'h0800_0040, L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h00C, L, L, L, L, 32'h1000_FFFD)};
        tbl[10] = '{S(L, 32'h0,         L, 2'd2, H, L, L, L, L, 32'h0),  E(L, 32'h00C, L, L, H, L, 32'h0800_0040)};
        tbl[11] = '{S(H, 32'h8C22_0000, L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h100, L, L, L, L, 32'h0800_0040)};
        tbl[12] = '{S(L, 32'h0,         L, 2'd0, H, L, H, L, L, 32'h0),  E(L, 32'h100, H, L, H, L, 32'h8C22_0000)};
        tbl[13] = '{S(L, 32'h0,         L, 2'd0, H, L, H, L, L, 32'h0),  E(L, 32'h100, H, L, H, L, 32'h8C22_0000)};
        tbl[14] = '{S(L, 32'h0,         L, 2'd0, H, L, H, L, L, 32'h0),  E(L, 32'h100, H, L, H, L, 32'h8C22_0000)};
        tbl[15] = '{S(L, 32'h0,         H, 2'd0, H, L, H, L, L, 32'h0),  E(L, 32'h100, H, L, H, L, 32'h8C22_0000)};
        tbl[16] = '{S(L, 32'h0,         H, 2'd0, H, L, H, H, L, 32'h0),  E(H, 32'h104, L, L, L, L, 32'h8C22_0000)};
        tbl[17] = '{S(H, 32'hAC22_0000, L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h104, L, L, L, L, 32'h8C22_0000)};
        tbl[18] = '{S(L, 32'h0,         L, 2'd0, H, L, L, H, L, 32'h0),  E(L, 32'h104, L, H, H, L, 32'hAC22_0000)};
        tbl[19] = '{S(L, 32'h0,         L, 2'd0, H, L, H, H, L, 32'h0),  E(L, 32'h104, H, L, H, L, 32'hAC22_0000)};
        tbl[20] = '{S(L, 32'h0,         H, 2'd0, H, L, L, H, L, 32'h0),  E(L, 32'h104, L, H, H, L, 32'hAC22_0000)};
        tbl[21] = '{S(H, 32'h2001_0001, L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h108, L, L, L, L, 32'hAC22_0000)};
        tbl[22] = '{S(L, 32'h0,         L, 2'd0, L, L, L, L, L, 32'h0),  E(L, 32'h108, L, L, H, L, 32'h2001_0001)};
        tbl[23] = '{S(H, 32'hFFFF_FFFF, L, 2'd0, H, L, L, L, L, 32'h0),  E(L, 32'h108, L, L, H, L, 32'h2001_0001)};
        tbl[24] = '{S(H, 32'h0000_000C, L, 2'd0, L, L, L, L, L, 32'h0),  E(H, 32'h10C, L, L, L, L, 32'h2001_0001)};
        tbl[25] = '{S(L, 32'h0,         L, 2'd0, H, L, L, L, H, 32'h0),  E(L, 32'h10C, L, L, H, L, 32'h0000_000C)};
        tbl[26] = '{S(H, 32'h1234_5678, H, 2'd0, H, L, H, H, L, 32'h0),  E(L, 32'h10C, L, L, L, H, 32'h0000_000C)};

        $display("[TB] starting fetch_sequencer bench");
        doReset();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(tbl[i].s);
            checkOutput($sformatf("vec%0d", i), tbl[i].e);
            tick();
        end

        // HALT must absorb any further hits
        for (int i = 0; i < 10; i++) begin
            applyStimulus(S(i[0], 32'hDEAD_BEEF, ~i[0], 2'd3, H, H, H, L, L, 32'h40));
            checkOutput($sformatf("halt_hold%0d", i), E(L, 32'h10C, L, L, L, H, 32'h0000_000C));
            tick();
        end

        doReset();
        idle();
        checkOutput("reset_from_halt", E(H, 32'h0, L, L, L, L, 32'h0));

        // jr to a high region, then j keeps pc_plus4[31:28]
        applyStimulus(S(H, 32'h0000_0008, L, 2'd0, L, L, L, L, L, 32'h0)); tick();
        applyStimulus(S(L, 32'h0, L, 2'd3, H, L, L, L, L, 32'h7000_0002)); tick();
        idle();
        checkOutput("jr_high", E(H, 32'h7000_0000, L, L, L, L, 32'h0000_0008));
        applyStimulus(S(H, 32'h0800_0040, L, 2'd0, L, L, L, L, L, 32'h0)); tick();
        applyStimulus(S(L, 32'h0, L, 2'd2, H, L, L, L, L, 32'h0)); tick();
        idle();
        checkOutput("j_high", E(H, 32'h7000_0100, L, L, L, L, 32'h0800_0040));

        // pc wrap at the top of the address space
        applyStimulus(S(H, 32'h0000_0008, L, 2'd0, L, L, L, L, L, 32'h0)); tick();
        applyStimulus(S(L, 32'h0, L, 2'd3, H, L, L, L, L, 32'hFFFF_FFFF)); tick();
        idle();
        checkOutput("jr_top", E(H, 32'hFFFF_FFFC, L, L, L, L, 32'h0000_0008));
        applyStimulus(S(H, 32'h2001_0005, L, 2'd0, L, L, L, L, L, 32'h0)); tick();
        applyStimulus(S(L, 32'h0, L, 2'd0, H, L, L, L, L, 32'h0)); tick();
        idle();
        checkOutput("pc_wrap", E(H, 32'h0, L, L, L, L, 32'h2001_0005));

        // advance to pc=4, then reset coinciding with ihit
        applyStimulus(S(H, 32'h2001_0005, L, 2'd0, L, L, L, L, L, 32'h0)); tick();
        applyStimulus(S(L, 32'h0, L, 2'd0, H, L, L, L, L, 32'h0)); tick();
        idle();
        checkOutput("pre_rst_ihit", E(H, 32'h4, L, L, L, L, 32'h2001_0005));
        applyStimulus(S(H, 32'h8C22_0000, L, 2'd0, L, L, L, L, L, 32'h0));
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        idle();
        checkOutput("rst_with_ihit", E(H, 32'h0, L, L, L, L, 32'h0));

        // reset coinciding with dhit in EXEC of a load
        applyStimulus(S(H, 32'h8C22_0000, L, 2'd0, L, L, L, L, L, 32'h0)); tick();
        applyStimulus(S(L, 32'h0, H, 2'd0, H, L, H, L, L, 32'h0));
        checkOutput("pre_rst_dhit", E(L, 32'h0, H, L, H, L, 32'h8C22_0000));
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        idle();
        checkOutput("rst_with_dhit", E(H, 32'h0, L, L, L, L, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-side counterpart of the control unit. Owns the PC, fetches instruction words from the memory controller, and drives opcode/funct into the control unit.
- Consumes the control unit's PC_src, PC_EN, bra, MemRead, MemWrite and mem_halt to sequence each instruction: fetch, execute (including any data access), then PC update or halt.
- Sits between the memory controller (i/d handshake) and the control unit/datapath in the multicycle CPU.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous, active-low reset.
- imemload  input  32  instruction word from memory controller.
- ihit  input  1  instruction read complete; imemload is valid this cycle.
- dhit  input  1  data access complete.
- PC_src  input  2  from control: 00 = +4, 01 = branch, 10 = jump, 11 = register.
- PC_EN  input  1  from control: allow PC update at the end of execute.
- bra  input  1  branch condition true; qualifies PC_src=01.
- MemRead  input  1  from control: current instruction reads data memory.
- MemWrite  input  1  from control: current instruction writes data memory.
- mem_halt  input  1  from control: current instruction is halt.
- rs_data  input  32  register-file rs value, used as the jr target.
- iREN  output  1  instruction read request.
- imemaddr  output  32  instruction address (= pc).
- dREN  output  1  data read request.
- dWEN  output  1  data write request.
- opcode  output  6  instr[31:26] to control.
- funct  output  6  instr[5:0] to control.
- instr  output  32  latched instruction word to datapath.
- pc_plus4  output  32  pc+4, used by jal writeback.
- exec_valid  output  1  high in EXEC; opcode/funct/instr are valid.
- halted  output  1  sticky halt flag.

Behaviour:
- All state updates on the rising CLK edge. nRST is sampled only at that edge; it has priority over every other input.
- Reset values:
  - pc = PC_INIT, instr = 32'h0, halted = 0, state = FETCH.
  - In the first cycle after the reset edge: iREN = 1, imemaddr = PC_INIT, dREN = dWEN = 0, exec_valid = 0.
- Outputs are decoded combinationally from state and registers.
  - imemaddr = pc.
  - pc_plus4 = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - opcode and funct are sliced from the instr register; they never come directly from imemload.
- FETCH:
  - iREN = 1.
  - On ihit: instr <= imemload, next state EXEC. Fetch latency is 1 cycle minimum.
  - Without ihit: hold in FETCH.
  - dhit in FETCH is ignored.
- EXEC:
  - exec_valid = 1.
  - dREN = MemRead. dWEN = MemWrite & ~MemRead; if both are asserted, read wins.
  - done = ~(MemRead | MemWrite) | dhit.
  - When done and mem_halt = 1: halted <= 1, next state HALT, pc is not updated.
  - When done and mem_halt = 0 and PC_EN = 1: pc <= next_pc, next state FETCH.
  - When done and PC_EN = 0: hold in EXEC (stall) and keep re-evaluating each cycle.
  - While not done: hold in EXEC.
  - ihit in EXEC is ignored.
- next_pc:
  - 00: pc + 4.
  - 01: if bra, (pc + 4) + ({{14{instr[15]}}, instr[15:0], 2'b00}); otherwise pc + 4.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: {rs_data[31:2], 2'b00}; the low bits are forced to 0.
  - All sums are 32-bit and wrap modulo 2^32.
- HALT:
  - Absorbing state; leaves only on reset.
  - iREN = dREN = dWEN = 0, exec_valid = 0, halted = 1. pc and instr hold.
- Reset mid-operation:
  - Reset during FETCH with ihit asserted in the same cycle: the instruction is discarded and state goes to FETCH at PC_INIT.
  - Reset during EXEC with dhit asserted: no pc update; requests drop the next cycle.
- Exactly one instruction is in flight at a time; no prefetch.

Test Plan:
- Reset, ihit one cycle later with imemload = 32'h2001_0005 (addi) -> after reset iREN = 1, imemaddr = 0; on ihit instr latched; next cycle opcode = 6'h08, exec_valid = 1; PC_src = 00, PC_EN = 1 -> pc = 4, state FETCH.
- beq at pc = 0x10 with imm = 16'hFFFD, PC_src = 01, bra = 1 -> pc = 0x10 + 4 - 12 = 0x08; repeat with bra = 0 -> pc = 0x14.
- j with instr[25:0] = 26'h0000040 at pc = 0x0040_0000 -> pc = 0x0000_0100; jr with rs_data = 32'h0000_0203 -> pc = 0x0000_0200.
- lw with MemRead = 1 and dhit delayed 3 cycles -> dREN high for exactly those cycles plus the hit cycle; pc is updated only on the dhit cycle. Same sequence with MemWrite -> dWEN high.
- halt (mem_halt = 1) -> halted = 1 the next cycle, iREN = 0, pc frozen; further ihit and dhit have no effect for 10 cycles.
- Assert nRST low in the same cycle as dhit during EXEC, and separately in the same cycle as ihit during FETCH -> pc = PC_INIT, halted = 0, state FETCH, no pc update or instruction latch.
